// File: rtl/tl_input_conditioner_if.sv
// Signal bundle between the traffic-light controller side and the input conditioner.
// The master drives raw inputs and controller pulses; the slave returns conditioned outputs.
interface tl_input_conditioner_if;
    logic walkButton;
    logic Sensor;
    logic walk_ack;
    logic tick_clr;
    logic walk_req;
    logic sensor_out;
    logic tick;

    modport master (
        output walkButton, Sensor, walk_ack, tick_clr,
        input  walk_req, sensor_out, tick
    );

    modport slave (
        input  walkButton, Sensor, walk_ack, tick_clr,
        output walk_req, sensor_out, tick
    );
endinterface

// File: rtl/tl_input_conditioner.sv
// Synchronizes and debounces the pedestrian button and vehicle sensor, latches walk requests
// and generates the tick timebase. Define TL_SENSOR_DEBOUNCE_EN to debounce the sensor too.
module tl_input_conditioner #(
    parameter int TICK_DIV  = 100000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    tl_input_conditioner_if.slave  bus
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

    typedef struct packed {
        logic            stable;
        logic [DB_W-1:0] cnt;
    } db_t;

    localparam db_t DB_IDLE = '{stable: 1'b0, cnt: {DB_W{1'b0}}};

    // A new level is accepted only after DB_CYCLES consecutive cycles of disagreement.
    function automatic db_t db_step(input logic sync, input db_t cur);
        db_t nxt;
        nxt = cur;
        if (sync == cur.stable) begin
            nxt.cnt = {DB_W{1'b0}};
        end else if (cur.cnt == DB_LAST) begin
            nxt.stable = sync;
            nxt.cnt    = {DB_W{1'b0}};
        end else begin
            nxt.cnt = cur.cnt + DB_W'(1);
        end
        return nxt;
    endfunction

    logic [1:0]        walk_sync_r;
    logic [1:0]        sensor_sync_r;
    db_t               walk_db_r;
    logic              walk_stable_d_r;
    logic              walk_req_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_r;

    // Button path: synchronizer, debouncer and request latch (a fresh rising edge beats ack).
    always_ff @(posedge clk) begin
        if (rst) begin
            walk_sync_r     <= 2'b00;
            walk_db_r       <= DB_IDLE;
            walk_stable_d_r <= 1'b0;
            walk_req_r      <= 1'b0;
        end else begin
            walk_sync_r     <= {walk_sync_r[0], bus.walkButton};
            walk_db_r       <= db_step(walk_sync_r[1], walk_db_r);
            walk_stable_d_r <= walk_db_r.stable;
            if (walk_db_r.stable && !walk_stable_d_r) begin
                walk_req_r <= 1'b1;
            end else if (bus.walk_ack) begin
                walk_req_r <= 1'b0;
            end else begin
                walk_req_r <= walk_req_r;
            end
        end
    end

`ifdef TL_SENSOR_DEBOUNCE_EN
    db_t sensor_db_r;

    // Sensor path: synchronizer followed by the same debouncer as the button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sensor_sync_r <= 2'b00;
            sensor_db_r   <= DB_IDLE;
        end else begin
            sensor_sync_r <= {sensor_sync_r[0], bus.Sensor};
            sensor_db_r   <= db_step(sensor_sync_r[1], sensor_db_r);
        end
    end

    assign bus.sensor_out = sensor_db_r.stable;
`else
    logic sensor_out_r;

    // Sensor path: synchronizer and a single output register, no debounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            sensor_sync_r <= 2'b00;
            sensor_out_r  <= 1'b0;
        end else begin
            sensor_sync_r <= {sensor_sync_r[0], bus.Sensor};
            sensor_out_r  <= sensor_sync_r[1];
        end
    end

    assign bus.sensor_out = sensor_out_r;
`endif

    // Tick timebase; tick_clr restarts the count and suppresses a coincident tick.
    always_ff @(posedge clk) begin
        if (rst || bus.tick_clr) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            tick_r     <= 1'b0;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            tick_r     <= 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            tick_r     <= 1'b0;
        end
    end

    assign bus.walk_req = walk_req_r;
    assign bus.tick     = tick_r;

endmodule

// File: tb/tb_tl_input_conditioner.sv
// Randomized and directed bench for tl_input_conditioner (TICK_DIV=10, DB_CYCLES=4) against a
// history-window reference model; honours TL_SENSOR_DEBOUNCE_EN like the design.
module tb_tl_input_conditioner;

    localparam int TD   = 10;
    localparam int DB   = 4;
    localparam int HIST = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tl_input_conditioner_if bus ();

    tl_input_conditioner #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: raw values sampled at each edge, newest at the back, zero-padded after reset.
    bit q_walk[$];
    bit q_sens[$];
    bit m_walk_st, m_walk_prev, m_req, m_sens_st, m_sens, m_tick;
    int m_since;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // True when the last DB synchronized samples (raw from 2+ edges ago) all differ from cur.
    function automatic bit window_flips(input bit q[$], input bit cur);
        bit all_diff = 1'b1;
        for (int i = 0; i < DB; i++) begin
            if (q[q.size() - 3 - i] == cur) all_diff = 1'b0;
        end
        return all_diff;
    endfunction

    task automatic model_reset();
        q_walk.delete();
        q_sens.delete();
        for (int i = 0; i < HIST; i++) begin
            q_walk.push_back(1'b0);
            q_sens.push_back(1'b0);
        end
        m_walk_st = 0; m_walk_prev = 0; m_req = 0;
        m_sens_st = 0; m_sens = 0; m_tick = 0; m_since = 0;
    endtask

    task automatic model_step(input bit w, input bit s, input bit a, input bit c, input bit r);
        bit st_before;
        if (r) begin
            model_reset();
        end else begin
            q_walk.push_back(w); void'(q_walk.pop_front());
            q_sens.push_back(s); void'(q_sens.pop_front());
            st_before = m_walk_st;
            if (m_walk_st && !m_walk_prev) m_req = 1;
            else if (a)                    m_req = 0;
            if (window_flips(q_walk, m_walk_st)) m_walk_st = !m_walk_st;
            m_walk_prev = st_before;
`ifdef TL_SENSOR_DEBOUNCE_EN
            if (window_flips(q_sens, m_sens_st)) m_sens_st = !m_sens_st;
            m_sens = m_sens_st;
`else
            m_sens = q_sens[q_sens.size() - 3];
`endif
            m_since++;
            m_tick = (m_since % TD) == 0;
            if (c) begin
                m_since = 0;
                m_tick  = 0;
            end
        end
    endtask

    task automatic cycle(input bit w, input bit s, input bit a, input bit c, input bit r);
        @(negedge clk);
        bus.walkButton = w;
        bus.Sensor     = s;
        bus.walk_ack   = a;
        bus.tick_clr   = c;
        rst            = r;
        @(posedge clk);
        model_step(w, s, a, c, r);
        #1;
        check("walk_req", {31'd0, bus.walk_req}, {31'd0, m_req});
        check("sensor_out", {31'd0, bus.sensor_out}, {31'd0, m_sens});
        check("tick", {31'd0, bus.tick}, {31'd0, m_tick});
    endtask

    int  lat, ticks, first_tick, seen;
    bit  rw, rs;
    int  rw_left, rs_left;

    initial begin
        bus.walkButton = 1'b0; bus.Sensor = 1'b0; bus.walk_ack = 1'b0; bus.tick_clr = 1'b0;
        rst = 1'b1;
        model_reset();

        // Reset then idle: ticks at 10 and 20.
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("rst_walk_req", {31'd0, bus.walk_req}, 32'd0);
        ticks = 0; first_tick = 0;
        for (int i = 1; i <= 25; i++) begin
            cycle(0, 0, 0, 0, 0);
            if (bus.tick === 1'b1) begin
                ticks++;
                if (first_tick == 0) first_tick = i;
            end
        end
        check("idle_tick_count", ticks, 32'd2);
        check("idle_first_tick", first_tick, 32'd10);

        // Two-cycle glitch must not register.
        seen = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0, 0);
            if (bus.walk_req === 1'b1) seen = 1;
        end
        check("glitch_req", seen, 32'd0);

        // Held press: walk_req 7 edges after the rise.
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (bus.walk_req === 1'b1) lat = i;
        end
        check("walk_latency", lat, 32'd7);

        // Ack while held, no re-arm.
        cycle(1, 0, 1, 0, 0);
        check("ack_clears", {31'd0, bus.walk_req}, 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (bus.walk_req === 1'b1) seen = 1;
        end
        check("hold_no_rearm", seen, 32'd0);

        // Release then press again.
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (bus.walk_req === 1'b1) lat = i;
        end
        check("repress_latency", lat, 32'd7);

        // Ack coinciding with the set edge: set wins.
        cycle(1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) cycle(1, 0, (i == 7), 0, 0);
        check("ack_vs_set", {31'd0, bus.walk_req}, 32'd1);

        // tick_clr with counter at 9 suppresses the tick; next one 10 cycles later.
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        check("clr_suppress", {31'd0, bus.tick}, 32'd0);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cycle(0, 0, 0, 0, 0);
            if (bus.tick === 1'b1) lat = i;
        end
        check("clr_next_tick", lat, 32'd10);

        // Steady sensor latency.
        cycle(0, 0, 0, 0, 1);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cycle(0, 1, 0, 0, 0);
            if (bus.sensor_out === 1'b1) lat = i;
        end
`ifdef TL_SENSOR_DEBOUNCE_EN
        check("sensor_latency", lat, 32'd6);
`else
        check("sensor_latency", lat, 32'd3);
`endif

        // Reset mid-count clears everything; held button re-arms after reset.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 1);
        check("midrst_outputs", {29'd0, bus.walk_req, bus.sensor_out, bus.tick}, 32'd0);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            cycle(1, 1, 0, 0, 0);
            if (bus.walk_req === 1'b1) lat = i;
        end
        check("post_rst_latency", lat, 32'd7);

        // Randomized run: hold lengths straddle DB_CYCLES.
        rw = 0; rs = 0; rw_left = 0; rs_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (rw_left == 0) begin rw = !rw; rw_left = $urandom_range(1, 8); end
            if (rs_left == 0) begin rs = !rs; rs_left = $urandom_range(1, 8); end
            rw_left--; rs_left--;
            cycle(rw, rs, ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
